ex_hazard_forward_unit: RTL and testbench

Parametrised successor to the EX-stage forwarding logic. It owns an internal scoreboard of in-flight destination registers, so downstream write addresses no longer need to be fed in. It produces per-operand forward selects for the instruction in EX, and detects load-use hazards, stalling ID/IF and inserting EX bubbles. It sits between the ID/EX pipeline register control and the EX operand muxes.

---
 rtl/ex_hazard_forward_unit.sv | 154 +++++++++++++++
 tb/tb_ex_hazard_forward_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_forward_unit.sv
// EX-stage hazard and forwarding unit.
// Tracks in-flight destination registers in a small internal scoreboard
// (slot 0 = EX, slots 1..FWD_DEPTH = downstream stages). From that state it
// produces per-operand forward selects for the instruction in EX, and it
// detects load-use hazards against the instruction in ID.
// Optional build macro HAZARD_PERF_EN adds saturating stall/forward counters.
module ex_hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_stall_ext,
    input  logic                          i_flush,
    input  logic                          i_id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rs,
    input  logic [NUM_SRC-1:0]            i_id_rs_used,
    input  logic [REG_ADDR_W-1:0]         i_id_rd,
    input  logic                          i_id_reg_write,
    input  logic                          i_id_is_load,
    output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
    output logic                          o_stall,
    output logic                          o_bubble
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                   o_stall_cnt,
    output logic [31:0]                   o_fwd_cnt
`endif
);

    // A load must become forwardable somewhere inside the tracked window.
    generate
        if (LOAD_LAT < 1 || (1 + LOAD_LAT) > FWD_DEPTH) begin : g_param_check
            $error("ex_hazard_forward_unit: need 1 <= LOAD_LAT and 1+LOAD_LAT <= FWD_DEPTH");
        end
    endgenerate

    // Scoreboard slots; only the EX slot keeps its source operands.
    logic                          slot_valid_reg   [0:FWD_DEPTH];
    logic [REG_ADDR_W-1:0]         slot_rd_reg      [0:FWD_DEPTH];
    logic                          slot_rw_reg      [0:FWD_DEPTH];
    logic                          slot_is_load_reg [0:FWD_DEPTH];
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_reg;
    logic [NUM_SRC-1:0]            ex_rs_used_reg;

    logic [FWD_DEPTH:0]            slot_writable;
    logic [FWD_DEPTH:0]            slot_ready;
    logic [NUM_SRC-1:0]            op_hazard;

    // Per-slot qualifiers: a load only becomes a forwarding source once it
    // has travelled LOAD_LAT stages past EX/MEM.
    genvar gi;
    generate
        for (gi = 0; gi <= FWD_DEPTH; gi++) begin : g_slot
            assign slot_writable[gi] = slot_valid_reg[gi] && slot_rw_reg[gi] &&
                                       (slot_rd_reg[gi] != '0);
            assign slot_ready[gi]    = slot_writable[gi] &&
                                       (!slot_is_load_reg[gi] || (gi >= 1 + LOAD_LAT));
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_op
            logic [REG_ADDR_W-1:0] ex_src;
            logic [REG_ADDR_W-1:0] id_src;
            logic [SEL_W-1:0]      sel;
            logic                  hit;

            assign ex_src = ex_rs_reg[gi*REG_ADDR_W +: REG_ADDR_W];
            assign id_src = i_id_rs[gi*REG_ADDR_W +: REG_ADDR_W];

            // Forward select: scan oldest to youngest so the youngest match wins.
            always_comb begin
                sel = '0;
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (slot_ready[k] && (slot_rd_reg[k] == ex_src)) begin
                        sel = SEL_W'(k);
                    end
                end
                if (!slot_valid_reg[0] || !ex_rs_used_reg[gi]) begin
                    sel = '0;
                end
            end

            // Load-use hazard: ID operand depends on a load whose data is not
            // forwardable by the time ID reaches EX.
            always_comb begin
                hit = 1'b0;
                for (int p = 0; p <= FWD_DEPTH; p++) begin
                    if ((p < LOAD_LAT) && slot_writable[p] && slot_is_load_reg[p] &&
                        (slot_rd_reg[p] == id_src)) begin
                        hit = 1'b1;
                    end
                end
                hit = hit && i_id_rs_used[gi];
            end

            assign o_fwd_sel[gi*SEL_W +: SEL_W] = sel;
            assign op_hazard[gi]                = hit;
        end
    endgenerate

    // Flush overrides the stall; any non-advancing ID becomes an EX bubble.
    assign o_stall  = i_id_valid && !i_flush && (|op_hazard);
    assign o_bubble = o_stall || i_flush || !i_id_valid;

    // Scoreboard advance: shift downstream, capture ID (or a bubble) into EX.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                slot_valid_reg[k]   <= 1'b0;
                slot_rd_reg[k]      <= '0;
                slot_rw_reg[k]      <= 1'b0;
                slot_is_load_reg[k] <= 1'b0;
            end
            ex_rs_reg      <= '0;
            ex_rs_used_reg <= '0;
        end else if (!i_stall_ext) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                slot_valid_reg[k]   <= slot_valid_reg[k-1];
                slot_rd_reg[k]      <= slot_rd_reg[k-1];
                slot_rw_reg[k]      <= slot_rw_reg[k-1];
                slot_is_load_reg[k] <= slot_is_load_reg[k-1];
            end
            slot_valid_reg[0]   <= !o_bubble;
            slot_rd_reg[0]      <= i_id_rd;
            slot_rw_reg[0]      <= i_id_reg_write;
            slot_is_load_reg[0] <= i_id_is_load;
            ex_rs_reg           <= i_id_rs;
            ex_rs_used_reg      <= i_id_rs_used;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters, frozen together with the pipeline.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
            o_fwd_cnt   <= '0;
        end else if (!i_stall_ext) begin
            if (o_stall && (o_stall_cnt != 32'hFFFF_FFFF)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            if ((|o_fwd_sel) && (o_fwd_cnt != 32'hFFFF_FFFF)) begin
                o_fwd_cnt <= o_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_forward_unit.sv
// Bench for ex_hazard_forward_unit: a default instance (FWD_DEPTH=2,
// LOAD_LAT=1) driven from a vector table, and a FWD_DEPTH=3/LOAD_LAT=2
// instance for the longer load-use stall. Expectations go through a queue
// and are compared on the falling edge.
module tb_ex_hazard_forward_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // default instance
    logic       stall_ext, flush, id_valid, id_rw, id_ld;
    logic [9:0] id_rs;
    logic [1:0] id_used;
    logic [4:0] id_rd;
    logic [3:0] fwd_sel;
    logic       stall, bubble;
    // deep instance
    logic       b_stall_ext, b_flush, b_id_valid, b_id_rw, b_id_ld;
    logic [9:0] b_id_rs;
    logic [1:0] b_id_used;
    logic [4:0] b_id_rd;
    logic [3:0] b_fwd_sel;
    logic       b_stall, b_bubble;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, fwd_cnt, b_stall_cnt, b_fwd_cnt;
`endif

    ex_hazard_forward_unit dut (
        .i_clk(clk), .i_rst(rst), .i_stall_ext(stall_ext), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rs_used(id_used),
        .i_id_rd(id_rd), .i_id_reg_write(id_rw), .i_id_is_load(id_ld),
        .o_fwd_sel(fwd_sel), .o_stall(stall), .o_bubble(bubble)
`ifdef HAZARD_PERF_EN
        , .o_stall_cnt(stall_cnt), .o_fwd_cnt(fwd_cnt)
`endif
    );

    ex_hazard_forward_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stall_ext(b_stall_ext), .i_flush(b_flush),
        .i_id_valid(b_id_valid), .i_id_rs(b_id_rs), .i_id_rs_used(b_id_used),
        .i_id_rd(b_id_rd), .i_id_reg_write(b_id_rw), .i_id_is_load(b_id_ld),
        .o_fwd_sel(b_fwd_sel), .o_stall(b_stall), .o_bubble(b_bubble)
`ifdef HAZARD_PERF_EN
        , .o_stall_cnt(b_stall_cnt), .o_fwd_cnt(b_fwd_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic [4:0] rd, rs0, rs1;
        logic [1:0] used;
        logic       rw, ld, fl, sx;
        logic [1:0] s0, s1;
        logic       st, bb;
    } vec_t;

    typedef struct {
        bit         is_b;
        string      tag;
        logic [1:0] s0, s1;
        logic       st, bb;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(bit v, int rd, int rs0, int rs1, int used, bit rw, bit ld,
                                bit fl, bit sx, int s0, int s1, bit st, bit bb);
        vec_t r;
        r.v = v; r.rd = 5'(rd); r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
        r.rw = rw; r.ld = ld; r.fl = fl; r.sx = sx;
        r.s0 = 2'(s0); r.s1 = 2'(s1); r.st = st; r.bb = bb;
        return r;
    endfunction

    task automatic check(string tag, string what, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %0h, expected %0h", tag, what, act, req);
        end
    endtask

    task automatic push_exp(bit is_b, string tag, vec_t t);
        exp_t e;
        e.is_b = is_b; e.tag = tag; e.s0 = t.s0; e.s1 = t.s1; e.st = t.st; e.bb = t.bb;
        exp_q.push_back(e);
    endtask

    task automatic drive_a(vec_t t, string tag);
        @(posedge clk);
        #1;
        id_valid = t.v; id_rd = t.rd; id_rs = {t.rs1, t.rs0}; id_used = t.used;
        id_rw = t.rw; id_ld = t.ld; flush = t.fl; stall_ext = t.sx;
        push_exp(1'b0, tag, t);
    endtask

    task automatic drive_b(vec_t t, string tag);
        @(posedge clk);
        #1;
        b_id_valid = t.v; b_id_rd = t.rd; b_id_rs = {t.rs1, t.rs0}; b_id_used = t.used;
        b_id_rw = t.rw; b_id_ld = t.ld; b_flush = t.fl; b_stall_ext = t.sx;
        push_exp(1'b1, tag, t);
    endtask

    // Scoreboard: compare one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.is_b) begin
                $display("%0t %s sel0=%0d sel1=%0d stall=%0b bubble=%0b",
                         $time, e.tag, fwd_sel[1:0], fwd_sel[3:2], stall, bubble);
                check(e.tag, "sel0",   32'(fwd_sel[1:0]), 32'(e.s0));
                check(e.tag, "sel1",   32'(fwd_sel[3:2]), 32'(e.s1));
                check(e.tag, "stall",  32'(stall),        32'(e.st));
                check(e.tag, "bubble", 32'(bubble),       32'(e.bb));
            end else begin
                $display("%0t %s sel0=%0d sel1=%0d stall=%0b bubble=%0b",
                         $time, e.tag, b_fwd_sel[1:0], b_fwd_sel[3:2], b_stall, b_bubble);
                check(e.tag, "sel0",   32'(b_fwd_sel[1:0]), 32'(e.s0));
                check(e.tag, "sel1",   32'(b_fwd_sel[3:2]), 32'(e.s1));
                check(e.tag, "stall",  32'(b_stall),        32'(e.st));
                check(e.tag, "bubble", 32'(b_bubble),       32'(e.bb));
            end
        end
    end

    initial begin
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        //          v  rd rs0 rs1 use rw ld fl sx  s0 s1 st bb
        // add r3 ; sub r5,r3,r4 back to back
        tbl.push_back(mk(1,  3,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5,  3,  4, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(nop);
        tbl.push_back(nop);
        // distance 2 (sel=2)
        tbl.push_back(mk(1,  3,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  7,  8,  9, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10,  4,  3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
        // distance 3 (sel=0)
        tbl.push_back(mk(1,  3,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  7,  8,  9, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 12, 13, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10,  3,  3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop);
        tbl.push_back(nop);
        tbl.push_back(nop);
        // two writers of r5 in flight, youngest wins on both operands
        tbl.push_back(mk(1,  5,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6,  5,  5, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(nop);
        tbl.push_back(nop);
        // lw r4 ; add r6,r4,r4 -> one stall cycle, then sel=2,2
        tbl.push_back(mk(1,  4,  1,  0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6,  4,  4, 3, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,  6,  4,  4, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 2, 2, 0, 1));
        tbl.push_back(nop);
        tbl.push_back(nop);
        // rd=0 load, reg_write=0 writer, rs_used=0 consumers
        tbl.push_back(mk(1,  0,  1,  2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6,  0,  0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  7,  1,  2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  8,  7,  7, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  9,  1,  2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10,  9,  9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11,  9,  9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop);
        tbl.push_back(nop);
        tbl.push_back(nop);
        // external freeze for 3 cycles while a forward is active
        tbl.push_back(mk(1,  3,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6,  3,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  7,  1,  3, 3, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1,  7,  1,  3, 3, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1,  7,  1,  3, 3, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1,  7,  1,  3, 3, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(nop);
        tbl.push_back(nop);
        // flush during a load-use hazard: no stall, bubble inserted
        tbl.push_back(mk(1,  4,  1,  2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6,  4,  5, 3, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(nop);
        tbl.push_back(nop);

        // reset state, with a valid non-hazard instruction presented in ID
        rst = 1'b1;
        stall_ext = 0; flush = 0; id_valid = 1; id_rd = 5'd1; id_rs = {5'd3, 5'd2};
        id_used = 2'b11; id_rw = 1; id_ld = 0;
        b_stall_ext = 0; b_flush = 0; b_id_valid = 0; b_id_rd = 0; b_id_rs = 0;
        b_id_used = 0; b_id_rw = 0; b_id_ld = 0;
        #12;
        check("reset", "sel",    32'(fwd_sel), 32'd0);
        check("reset", "stall",  32'(stall),   32'd0);
        check("reset", "bubble", 32'(bubble),  32'd0);
        id_valid = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_a(tbl[i], $sformatf("vec%0d", i));
        end
        drive_a(nop, "tail");
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check("perf", "stall_cnt", stall_cnt, 32'd1);
        check("perf", "fwd_cnt",   fwd_cnt,   32'd6);
`endif

        // deep instance: LOAD_LAT=2 -> two stall cycles, then sel=3
        drive_b(mk(1, 4, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0), "deep_lw");
        drive_b(mk(1, 6, 4, 4, 3, 1, 0, 0, 0, 0, 0, 1, 1), "deep_stall1");
        drive_b(mk(1, 6, 4, 4, 3, 1, 0, 0, 0, 0, 0, 1, 1), "deep_stall2");
        drive_b(mk(1, 6, 4, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0), "deep_release");
        drive_b(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 1), "deep_fwd");
        drive_b(nop, "deep_tail");

        // async reset with two writers of r3 in flight
        drive_a(mk(1, 3, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0), "rst_w1");
        drive_a(mk(1, 3, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0), "rst_w2");
        drive_a(mk(1, 6, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0), "rst_rd");
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), "rst_pre");
        #6;
        rst = 1'b1;
        #1;
        check("async_rst", "sel",   32'(fwd_sel), 32'd0);
        check("async_rst", "stall", 32'(stall),   32'd0);
`ifdef HAZARD_PERF_EN
        check("async_rst", "stall_cnt", stall_cnt, 32'd0);
        check("async_rst", "fwd_cnt",   fwd_cnt,   32'd0);
`endif
        #1;
        rst = 1'b0;
        drive_a(mk(1, 6, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0), "post_rst_c");
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "post_rst_ex");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
